// File: rtl/comparator_pkg.sv
// -----------------------------------------------------------------------------
// comparator_pkg
// Shared constants for the registered magnitude comparator.
//   DEFAULT_WIDTH : default operand width
//   CMP_*         : 3-bit one-hot result encoding, bit order {equal, greator, lesser}
//   cmp_encode()  : folds the cascade's gt/lt pair into the result encoding
// Optional feature macro used elsewhere in this slice: COMPARATOR_SIGNED_EN
// -----------------------------------------------------------------------------
package comparator_pkg;

   localparam int DEFAULT_WIDTH = 4;

   localparam logic [2:0] CMP_EQ   = 3'b100;
   localparam logic [2:0] CMP_GT   = 3'b010;
   localparam logic [2:0] CMP_LT   = 3'b001;
   localparam logic [2:0] CMP_NONE = 3'b000;

   // The cascade never raises gt and lt together, so neither flag means equal.
   function automatic logic [2:0] cmp_encode(input logic gt, input logic lt);
      if (gt)      return CMP_GT;
      else if (lt) return CMP_LT;
      else         return CMP_EQ;
   endfunction

endpackage

// File: rtl/comparator_if.sv
// -----------------------------------------------------------------------------
// comparator_if
// Bundles the comparator's operand/strobe inputs and flag outputs.
//   in_valid    : A/B (and signed_mode) are sampled on a clk edge when high
//   A, B        : WIDTH-bit operands
//   signed_mode : two's complement compare (only with COMPARATOR_SIGNED_EN)
//   equal/greator/lesser : registered one-hot flags
//   out_valid   : flags belong to the pair accepted on the previous edge
// Handshake: valid-only, no ready. Every in_valid=1 edge is accepted and
// produces out_valid=1 exactly one edge later; there is no backpressure.
// Modports: master drives operands (bench/upstream), slave is the comparator.
// -----------------------------------------------------------------------------
interface comparator_if
   import comparator_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) ();

   logic             in_valid;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
`ifdef COMPARATOR_SIGNED_EN
   logic             signed_mode;
`endif
   logic             equal;
   logic             greator;
   logic             lesser;
   logic             out_valid;

`ifdef COMPARATOR_SIGNED_EN
   modport master (output in_valid, A, B, signed_mode,
                   input  equal, greator, lesser, out_valid);
   modport slave  (input  in_valid, A, B, signed_mode,
                   output equal, greator, lesser, out_valid);
`else
   modport master (output in_valid, A, B,
                   input  equal, greator, lesser, out_valid);
   modport slave  (input  in_valid, A, B,
                   output equal, greator, lesser, out_valid);
`endif

endinterface

// File: rtl/comparator_bit_slice.sv
// -----------------------------------------------------------------------------
// comparator_bit_slice
// One cell of an MSB-first magnitude compare cascade.
//   a, b         : operand bits at this position
//   gt_in, lt_in : decision from the more significant bits
//   gt_out       : A > B decided at or above this bit
//   lt_out       : A < B decided at or above this bit
// Once a more significant bit has decided, this cell only passes it along.
// -----------------------------------------------------------------------------
module comparator_bit_slice (
   input  logic a,
   input  logic b,
   input  logic gt_in,
   input  logic lt_in,
   output logic gt_out,
   output logic lt_out
);

   assign gt_out = gt_in | (~lt_in &  a & ~b);
   assign lt_out = lt_in | (~gt_in & ~a &  b);

endmodule

// File: rtl/comparator.sv
// -----------------------------------------------------------------------------
// comparator
// Registered magnitude comparator: one clock from accepted A/B to flags.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset (priority over in_valid)
//   bus : comparator_if.slave -- in_valid, A, B, [signed_mode] in;
//         equal, greator, lesser, out_valid out
// Flags hold when in_valid=0 and are all zero until the first accepted pair.
// Optional macro COMPARATOR_SIGNED_EN adds signed_mode for two's complement
// compares; without it the compare is always unsigned.
// -----------------------------------------------------------------------------
module comparator
   import comparator_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic         clk,
   input  logic         rst,
   comparator_if.slave  bus
);

   logic [WIDTH-1:0] a_eff;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   gt_c;
   logic [WIDTH:0]   lt_c;
   logic [2:0]       cmp_next;
   logic [2:0]       result_q;
   logic             valid_q;

   // Signed compare: swapping the sign bits between the operands makes a
   // negative value lose at the MSB, after which the lower bits compare as
   // ordinary unsigned magnitude.
   always_comb begin
      a_eff = bus.A;
      b_eff = bus.B;
`ifdef COMPARATOR_SIGNED_EN
      if (bus.signed_mode) begin
         a_eff[WIDTH-1] = bus.B[WIDTH-1];
         b_eff[WIDTH-1] = bus.A[WIDTH-1];
      end
`endif
   end

   // Cascade runs from the MSB (index WIDTH-1) down to the LSB.
   assign gt_c[WIDTH] = 1'b0;
   assign lt_c[WIDTH] = 1'b0;

   for (genvar i = WIDTH - 1; i >= 0; i--) begin : g_slice
      comparator_bit_slice u_slice (
         .a      (a_eff[i]),
         .b      (b_eff[i]),
         .gt_in  (gt_c[i+1]),
         .lt_in  (lt_c[i+1]),
         .gt_out (gt_c[i]),
         .lt_out (lt_c[i])
      );
   end

   assign cmp_next = cmp_encode(gt_c[0], lt_c[0]);

   // The result register only loads on accepted pairs, so idle-cycle
   // operands (including X) never reach the flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         result_q <= CMP_NONE;
         valid_q  <= 1'b0;
      end else begin
         valid_q <= bus.in_valid;
         if (bus.in_valid) begin
            result_q <= cmp_next;
         end
      end
   end

   assign bus.equal     = result_q[2];
   assign bus.greator   = result_q[1];
   assign bus.lesser    = result_q[0];
   assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_comparator.sv
// -----------------------------------------------------------------------------
// tb_comparator
// Directed bench for comparator (WIDTH=4). Observed vector per check is
// {out_valid, equal, greator, lesser}. Define COMPARATOR_SIGNED_EN to also
// exercise the signed_mode port.
// -----------------------------------------------------------------------------
module tb_comparator;

   localparam int W = 4;

   logic clk;
   logic rst;

   int checks = 0;
   int fails  = 0;

   logic [3:0] exp_q[$];

   comparator_if #(.WIDTH(W)) cif ();

   comparator #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (cif)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver tasks
   task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
      cif.in_valid = v;
      cif.A        = a;
      cif.B        = b;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // scoreboard: compare DUT against the head of the expected queue
   task automatic check(input string tag);
      logic [3:0] obs;
      logic [3:0] exp;
      obs = {cif.out_valid, cif.equal, cif.greator, cif.lesser};
      if (exp_q.size() == 0) begin
         exp = 4'bxxxx;
      end else begin
         exp = exp_q.pop_front();
      end
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // reference model for the exhaustive sweep
   function automatic logic [3:0] model(input int a, input int b);
      if (a == b)     return 4'b1100;
      else if (a > b) return 4'b1010;
      else            return 4'b1001;
   endfunction

   initial begin
      rst = 1'b1;
      drive(1'b1, 4'd4, 4'd3);
`ifdef COMPARATOR_SIGNED_EN
      cif.signed_mode = 1'b0;
`endif

      // reset held two cycles with a valid pair present
      step(); exp_q.push_back(4'b0000); check("reset_cycle1");
      step(); exp_q.push_back(4'b0000); check("reset_cycle2");

      // release reset, idle: still nothing accepted
      rst = 1'b0;
      drive(1'b0, 4'd0, 4'd0);
      step(); exp_q.push_back(4'b0000); check("idle_after_reset");

      // directed pairs, back-to-back
      drive(1'b1, 4'd4,  4'd3);  step(); exp_q.push_back(4'b1010); check("pair_4_3");
      drive(1'b1, 4'd2,  4'd2);  step(); exp_q.push_back(4'b1100); check("pair_2_2");
      drive(1'b1, 4'd1,  4'd5);  step(); exp_q.push_back(4'b1001); check("pair_1_5");
      drive(1'b1, 4'd7,  4'd7);  step(); exp_q.push_back(4'b1100); check("pair_7_7");
      drive(1'b1, 4'd0,  4'd0);  step(); exp_q.push_back(4'b1100); check("pair_0_0");
      drive(1'b1, 4'd3,  4'd6);  step(); exp_q.push_back(4'b1001); check("pair_3_6");
      drive(1'b1, 4'd15, 4'd8);  step(); exp_q.push_back(4'b1010); check("pair_15_8");
      drive(1'b1, 4'd12, 4'd12); step(); exp_q.push_back(4'b1100); check("pair_12_12");
      drive(1'b1, 4'd15, 4'd0);  step(); exp_q.push_back(4'b1010); check("pair_max_0");
      drive(1'b1, 4'd0,  4'd15); step(); exp_q.push_back(4'b1001); check("pair_0_max");

      // hold: accept 15/8, then idle with new operands
      drive(1'b1, 4'd15, 4'd8);  step(); exp_q.push_back(4'b1010); check("hold_accept");
      drive(1'b0, 4'd0,  4'd9);  step(); exp_q.push_back(4'b0010); check("hold_idle");

      // X on operands while idle must not reach the flags
      drive(1'b0, 4'bxxxx, 4'bxxxx); step(); exp_q.push_back(4'b0010); check("hold_x_idle");

      // reset on the same edge as a valid pair
      rst = 1'b1;
      drive(1'b1, 4'd1, 4'd5);   step(); exp_q.push_back(4'b0000); check("midstream_reset");
      rst = 1'b0;
      drive(1'b0, 4'd1, 4'd5);   step(); exp_q.push_back(4'b0000); check("post_reset_idle");

`ifdef COMPARATOR_SIGNED_EN
      cif.signed_mode = 1'b1;
      drive(1'b1, 4'b1000, 4'b0111); step(); exp_q.push_back(4'b1001); check("signed_min_vs_pos");
      drive(1'b1, 4'b1111, 4'b1110); step(); exp_q.push_back(4'b1010); check("signed_m1_vs_m2");
      drive(1'b1, 4'b0001, 4'b1111); step(); exp_q.push_back(4'b1010); check("signed_p1_vs_m1");
      cif.signed_mode = 1'b0;
      drive(1'b1, 4'b1000, 4'b0111); step(); exp_q.push_back(4'b1010); check("unsigned_8_vs_7");
`endif

      // exhaustive sweep, one pair per cycle
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            drive(1'b1, W'(a), W'(b));
            step();
            exp_q.push_back(model(a, b));
            check($sformatf("sweep_%0d_%0d", a, b));
         end
      end

      // stream ends: valid drops, last result (15 vs 15 -> equal) holds
      drive(1'b0, 4'd3, 4'd9);   step(); exp_q.push_back(4'b0100); check("sweep_end_hold");

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
